exe_muldiv_unit: RTL and testbench

- Multi-cycle multiply/divide engine in the EXE stage, fed by the ID/EXE pipeline register outputs.
- Executes MULT, MULTU, DIV and DIVU and holds the EXE stage through a stall request while it iterates.
- Presents a 64-bit HI/LO result to the EXE/MEM register in the cycle the stall drops, for writeback through the HIWr/LOWr path.

---
 rtl/exe_muldiv_unit_if.sv | 31 +++
 rtl/exe_muldiv_unit.sv | 172 +++++++++++++++++
 tb/tb_exe_muldiv_unit.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/exe_muldiv_unit_if.sv
// EXE-stage multiply/divide request/result bundle. The pipeline side drives the
// request (master); the muldiv unit answers with stall/done/HI/LO (slave).
interface exe_muldiv_unit_if #(
  parameter int DATA_W = 32
);
  // Handshake: start_i is a level request held for as long as the instruction
  // sits in EXE. stall_o is the back-pressure: while it is high the request
  // is being worked on and the pipeline must not advance. done_o pulses for
  // exactly one cycle with hi_o/lo_o valid, and in that cycle stall_o is low,
  // so the instruction leaves EXE. flush_i cancels any request outright.
  logic              start_i;
  logic [1:0]        op_i;
  logic [DATA_W-1:0] src_a_i;
  logic [DATA_W-1:0] src_b_i;
  logic              flush_i;
  logic              stall_o;
  logic              done_o;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;
  logic [1:0]        state_dbg;

  modport master (
    output start_i, op_i, src_a_i, src_b_i, flush_i,
    input  stall_o, done_o, hi_o, lo_o, state_dbg
  );

  modport slave (
    input  start_i, op_i, src_a_i, src_b_i, flush_i,
    output stall_o, done_o, hi_o, lo_o, state_dbg
  );
endinterface

// File: rtl/exe_muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine for the EXE stage (shift-add multiply,
// restoring divide). Define MULDIV_FAST_MULT_EN for a single-cycle multiply.
module exe_muldiv_unit #(
  parameter int DATA_W     = 32,
  parameter int ITER_CNT_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  exe_muldiv_unit_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int RW = 2 * DATA_W;

  state_t                state, state_nxt;
  logic [ITER_CNT_W-1:0] cnt, cnt_nxt;
  logic [RW-1:0]         work_q, work_nxt;
  logic [DATA_W-1:0]     opnd_q;
  logic                  is_div_q;
  logic                  neg_res_q;
  logic                  neg_rem_q;
  logic [DATA_W-1:0]     hi_q, lo_q;
  logic [DATA_W-1:0]     hi_nxt, lo_nxt;
  logic                  res_load;

  logic                  accept;
  logic                  div_by_zero;
  logic                  signed_op;
  logic                  a_neg, b_neg;
  logic [DATA_W-1:0]     abs_a, abs_b;
  logic                  last_iter;

  assign accept      = (state == S_IDLE) & bus.start_i & ~bus.flush_i;
  assign div_by_zero = accept & bus.op_i[1] & (bus.src_b_i == '0);
  assign signed_op   = ~bus.op_i[0];
  assign a_neg       = signed_op & bus.src_a_i[DATA_W-1];
  assign b_neg       = signed_op & bus.src_b_i[DATA_W-1];
  assign abs_a       = a_neg ? (DATA_W'(0) - bus.src_a_i) : bus.src_a_i;
  assign abs_b       = b_neg ? (DATA_W'(0) - bus.src_b_i) : bus.src_b_i;
  assign last_iter   = (cnt == ITER_CNT_W'(DATA_W - 1));

  // work_q layout: multiply keeps {partial product high, remaining multiplier};
  // divide keeps {partial remainder, dividend bits shifting into quotient}.
`ifdef MULDIV_FAST_MULT_EN
  logic [RW-1:0] fast_prod;
  assign fast_prod = RW'(opnd_q) * RW'(work_q[DATA_W-1:0]);
`else
  logic [DATA_W:0] mul_sum;
  logic [RW-1:0]   mul_step;
  assign mul_sum  = {1'b0, work_q[RW-1:DATA_W]} + (work_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_step = {mul_sum, work_q[DATA_W-1:1]};
`endif

  logic [DATA_W:0] div_diff;
  logic [RW-1:0]   div_step;
  assign div_diff = work_q[RW-1:DATA_W-1] - {1'b0, opnd_q};
  assign div_step = div_diff[DATA_W] ? {work_q[RW-2:0], 1'b0}
                                     : {div_diff[DATA_W-1:0], work_q[DATA_W-2:0], 1'b1};

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    work_nxt  = work_q;
    res_load  = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          cnt_nxt = '0;
          if (div_by_zero) begin
            state_nxt = S_DONE;
            res_load  = 1'b1;
          end else if (bus.op_i[1]) begin
            state_nxt = S_DIV;
            work_nxt  = {{DATA_W{1'b0}}, abs_a};
          end else begin
            state_nxt = S_MUL;
            work_nxt  = {{DATA_W{1'b0}}, abs_b};
          end
        end
      end
      S_MUL: begin
`ifdef MULDIV_FAST_MULT_EN
        work_nxt  = fast_prod;
        state_nxt = S_DONE;
        res_load  = 1'b1;
`else
        work_nxt = mul_step;
        cnt_nxt  = cnt + ITER_CNT_W'(1);
        if (last_iter) begin
          state_nxt = S_DONE;
          res_load  = 1'b1;
        end
`endif
      end
      S_DIV: begin
        work_nxt = div_step;
        cnt_nxt  = cnt + ITER_CNT_W'(1);
        if (last_iter) begin
          state_nxt = S_DONE;
          res_load  = 1'b1;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (bus.flush_i) begin
      state_nxt = S_IDLE;
      res_load  = 1'b0;
    end
  end

  // Sign correction applied to the final magnitude as it is captured.
  logic [DATA_W-1:0] quo_mag, rem_mag;
  logic [RW-1:0]     prod_fix;
  assign quo_mag  = work_nxt[DATA_W-1:0];
  assign rem_mag  = work_nxt[RW-1:DATA_W];
  assign prod_fix = neg_res_q ? (RW'(0) - work_nxt) : work_nxt;

  always_comb begin
    hi_nxt = prod_fix[RW-1:DATA_W];
    lo_nxt = prod_fix[DATA_W-1:0];
    if (state == S_IDLE) begin
      // Divide by zero: quotient all ones, remainder is the raw dividend.
      hi_nxt = bus.src_a_i;
      lo_nxt = '1;
    end else if (is_div_q) begin
      lo_nxt = neg_res_q ? (DATA_W'(0) - quo_mag) : quo_mag;
      hi_nxt = neg_rem_q ? (DATA_W'(0) - rem_mag) : rem_mag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      work_q    <= '0;
      opnd_q    <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      work_q <= work_nxt;
      if (accept) begin
        opnd_q    <= bus.op_i[1] ? abs_b : abs_a;
        is_div_q  <= bus.op_i[1];
        neg_res_q <= a_neg ^ b_neg;
        neg_rem_q <= a_neg;
      end
      if (res_load) begin
        hi_q <= hi_nxt;
        lo_q <= lo_nxt;
      end
    end
  end

  assign bus.stall_o   = accept | (state == S_MUL) | (state == S_DIV);
  assign bus.done_o    = (state == S_DONE) & ~bus.flush_i;
  assign bus.hi_o      = hi_q;
  assign bus.lo_o      = lo_q;
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Self-checking bench for exe_muldiv_unit: directed cases, flush, back-to-back,
// mid-operation reset and randomized operations against an arithmetic model.
module tb_exe_muldiv_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exe_muldiv_unit_if #(.DATA_W(W)) bus();

  exe_muldiv_unit #(.DATA_W(W), .ITER_CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] last_result;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp_val);
    n_checks++;
    if (got !== exp_val) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp_val);
    end
  endtask

  // Reference: plain integer arithmetic, result packed as {hi, lo}.
  function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [31:0]     q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      2'b00: return 64'(sa * sb);
      2'b01: return ua * ub;
      2'b10: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = 32'(sa / sb);
        r = 32'(sa % sb);
        return {r, q};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        q = 32'(ua / ub);
        r = 32'(ua % ub);
        return {r, q};
      end
    endcase
  endfunction

  function automatic int exp_latency(input logic [1:0] op, input logic [31:0] b);
    if (op[1]) return (b == 32'd0) ? 1 : 33;
`ifdef MULDIV_FAST_MULT_EN
    return 2;
`else
    return 33;
`endif
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.start_i = 1'b0;
      bus.flush_i = 1'b0;
    end
  endtask

  // Issues one op and follows it to done_o; returns inside the done cycle.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [63:0] exp_val;
    int lat;
    int stall_cnt;
    int done_at;
    stall_cnt = 0;
    done_at   = -1;
    exp_q.push_back(ref_model(op, a, b));
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.src_a_i = a;
    bus.src_b_i = b;
    bus.flush_i = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (bus.done_o) begin
        done_at = c;
        break;
      end
      if (bus.stall_o) stall_cnt++;
      @(negedge clk);
    end
    lat     = exp_latency(op, b);
    exp_val = exp_q.pop_front();
    check_eq({tag, "_done_cycle"}, 64'(done_at), 64'(lat));
    check_eq({tag, "_stall_cycles"}, 64'(stall_cnt), 64'(lat));
    if (done_at >= 0) begin
      check_eq({tag, "_hilo"}, {bus.hi_o, bus.lo_o}, exp_val);
      check_eq({tag, "_stall_at_done"}, 64'(bus.stall_o), 64'd0);
      last_result = exp_val;
    end
  endtask

  logic [1:0]  d_op   [6] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b10, 2'b11};
  logic [31:0] d_a    [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'h8000_0000, 32'd5};
  logic [31:0] d_b    [6] = '{32'hFFFF_FFFF, 32'd3, 32'd2, 32'd7, 32'hFFFF_FFFF, 32'd0};
  logic [63:0] d_plan [6] = '{64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFF_FFFF_FFEB,
                              64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0002_0000_000E,
                              64'h0000_0000_8000_0000, 64'h0000_0005_FFFF_FFFF};

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_seen;
    logic [1:0]  r_op;
    logic [31:0] r_a, r_b;

    rst         = 1'b1;
    bus.start_i = 1'b0;
    bus.op_i    = 2'b00;
    bus.src_a_i = '0;
    bus.src_b_i = '0;
    bus.flush_i = 1'b0;
    last_result = '0;

    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_stall", 64'(bus.stall_o), 64'd0);
    check_eq("rst_done", 64'(bus.done_o), 64'd0);
    check_eq("rst_hi", 64'(bus.hi_o), 64'd0);
    check_eq("rst_lo", 64'(bus.lo_o), 64'd0);
    check_eq("rst_state", 64'(bus.state_dbg), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_op(d_op[i], d_a[i], d_b[i], $sformatf("dir%0d", i));
      check_eq($sformatf("dir%0d_plan", i), {bus.hi_o, bus.lo_o}, d_plan[i]);
      idle(1);
    end

    // Flush a divide in its tenth cycle.
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.op_i    = 2'b10;
    bus.src_a_i = 32'd1000;
    bus.src_b_i = 32'd3;
    repeat (10) @(negedge clk);
    #1;
    check_eq("flush_pre_stall", 64'(bus.stall_o), 64'd1);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    #1;
    check_eq("flush_stall_drop", 64'(bus.stall_o), 64'd0);
    check_eq("flush_state_idle", 64'(bus.state_dbg), 64'd0);
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (bus.done_o) done_seen++;
    end
    check_eq("flush_no_done", 64'(done_seen), 64'd0);
    check_eq("flush_hilo_kept", {bus.hi_o, bus.lo_o}, last_result);

    // Start and flush together: never leaves IDLE.
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.flush_i = 1'b1;
    bus.op_i    = 2'b00;
    bus.src_a_i = 32'd3;
    bus.src_b_i = 32'd3;
    for (int c = 0; c < 3; c++) begin
      #1;
      check_eq($sformatf("sf_stall%0d", c), 64'(bus.stall_o), 64'd0);
      check_eq($sformatf("sf_state%0d", c), 64'(bus.state_dbg), 64'd0);
      @(negedge clk);
    end
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    check_eq("sf_hilo_kept", {bus.hi_o, bus.lo_o}, last_result);

    // Back-to-back multiplies, then reset in the middle of a third.
    run_op(2'b00, 32'd2, 32'd3, "b2b0");
    check_eq("b2b0_lo", 64'(bus.lo_o), 64'd6);
    run_op(2'b00, 32'd4, 32'd5, "b2b1");
    check_eq("b2b1_lo", 64'(bus.lo_o), 64'd20);
    @(negedge clk);
    bus.op_i    = 2'b00;
    bus.src_a_i = 32'd9;
    bus.src_b_i = 32'd9;
    repeat (5) @(negedge clk);
    #1;
    bus.start_i = 1'b0;
    rst         = 1'b1;
    #1;
    check_eq("mrst_hi", 64'(bus.hi_o), 64'd0);
    check_eq("mrst_lo", 64'(bus.lo_o), 64'd0);
    check_eq("mrst_done", 64'(bus.done_o), 64'd0);
    check_eq("mrst_stall", 64'(bus.stall_o), 64'd0);
    check_eq("mrst_state", 64'(bus.state_dbg), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(1);

    for (int i = 0; i < 60; i++) begin
      r_op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 9))
        0:       r_b = 32'd0;
        1, 2:    r_b = 32'($urandom_range(1, 15));
        3:       r_b = 32'hFFFF_FFFF;
        4:       r_b = 32'd0 - 32'($urandom_range(1, 15));
        default: r_b = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       r_a = 32'h8000_0000;
        1:       r_a = 32'($urandom_range(0, 200));
        default: r_a = $urandom;
      endcase
      run_op(r_op, r_a, r_b, $sformatf("rnd%0d", i));
      idle($urandom_range(0, 2));
    end
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
